// File: rtl/pc_pkg.sv
// Shared definitions for the IF-stage PC generator: pc_src codes, FSM states
// and the exception-class classifier used by the target mux and redirect buffer.
package pc_pkg;

    localparam logic [2:0] PCSRC_SEQ   = 3'b000;
    localparam logic [2:0] PCSRC_BR    = 3'b001;
    localparam logic [2:0] PCSRC_J     = 3'b010;
    localparam logic [2:0] PCSRC_JR    = 3'b011;
    localparam logic [2:0] PCSRC_ILLOP = 3'b100;
    localparam logic [2:0] PCSRC_XADR  = 3'b101;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pc_state_t;

    // Illegal-opcode and interrupt/exception sources (100..111)
    function automatic logic is_exc(input logic [2:0] src);
        return (src >= PCSRC_ILLOP);
    endfunction

    // Interrupt/exception sources only (101..111); these are maskable in kernel mode
    function automatic logic is_xadr(input logic [2:0] src);
        return (src > PCSRC_ILLOP);
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry holding register for a redirect that arrives while the pipeline
// is stalled. An empty buffer accepts any capture; a full buffer is only
// overwritten by an exception-class redirect.
// Optional feature macro: PC_EPC_EN (stores the exception return address).
module pc_redirect_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            capture,
    input  logic            clear,
    input  logic [XLEN-1:0] in_target,
    input  logic            in_exc,
    input  logic [XLEN-1:0] in_exc_pc,
    output logic            valid,
    output logic [XLEN-1:0] target,
    output logic            exc,
    output logic [XLEN-1:0] exc_pc
);

    logic write_en;

    assign write_en = capture && (!valid || in_exc);

    // Entry valid/target/class register; clear takes priority over capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid  <= 1'b0;
            target <= '0;
            exc    <= 1'b0;
        end else if (clear) begin
            valid  <= 1'b0;
        end else if (write_en) begin
            valid  <= 1'b1;
            target <= in_target;
            exc    <= in_exc;
        end
    end

`ifdef PC_EPC_EN
    // Return address travels with the buffered exception redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_pc <= '0;
        end else if (!clear && write_en) begin
            exc_pc <= in_exc_pc;
        end
    end
`else
    logic unused_exc_pc;
    assign unused_exc_pc = ^in_exc_pc;
    assign exc_pc        = '0;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage PC generator: next-PC selection (sequential, branch, jump, jr,
// illegal-op and exception vectors), supervisor-bit protection, stall/redirect
// deferral through a one-entry buffer and a one-cycle boot state.
// Optional feature macro: PC_EPC_EN (drives epc on exception-class redirects).
module pc_fetch_unit import pc_pkg::*; #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
    parameter logic [XLEN-1:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [XLEN-1:0] XADR_VEC  = 32'h8000_0008
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      pc_src,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    input  logic [XLEN-1:0] reg_target,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            stall,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] epc
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_p0, pc_d;
    logic            kern;
    logic [2:0]      src_eff;
    logic            redir, new_exc;
    logic [XLEN-1:0] tgt;
    logic            buf_cap, buf_clr;
    logic            pend_valid, pend_exc;
    logic [XLEN-1:0] pend_tgt, pend_exc_pc;
    logic            epc_ld;
    logic [XLEN-1:0] epc_d;

    assign kern        = pc_p0[XLEN-1];
    assign pc          = pc_p0;
    assign pc_plus4    = {pc_p0[XLEN-1], pc_p0[XLEN-2:0] + (XLEN-1)'(4)};
    assign fetch_valid = (state_q != ST_BOOT);

    // Interrupts are masked in kernel mode; the redirect is then plain sequential
    assign src_eff = (is_xadr(pc_src) && kern) ? PCSRC_SEQ : pc_src;
    assign redir   = (src_eff != PCSRC_SEQ) && !((src_eff == PCSRC_BR) && !branch_taken);
    assign new_exc = is_exc(src_eff);

    // Target mux with supervisor-bit rules and word alignment
    always_comb begin
        tgt = XADR_VEC;
        case (src_eff)
            PCSRC_BR: begin
                tgt           = branch_target;
                tgt[XLEN-1]   = kern;
            end
            PCSRC_J: begin
                tgt           = jump_target;
                tgt[XLEN-1]   = kern;
            end
            PCSRC_JR: begin
                tgt           = reg_target;
                tgt[XLEN-1]   = kern & reg_target[XLEN-1];
            end
            PCSRC_ILLOP: tgt = ILLOP_VEC;
            default:     tgt = XADR_VEC;
        endcase
        tgt[1:0] = 2'b00;
    end

    // Next-state, next-PC and buffer control
    always_comb begin
        state_d = state_q;
        pc_d    = pc_p0;
        buf_cap = 1'b0;
        buf_clr = 1'b0;
        epc_ld  = 1'b0;
        epc_d   = exc_pc;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (stall) begin
                    if (redir) begin
                        buf_cap = 1'b1;
                        state_d = ST_HOLD;
                    end
                end else if (redir) begin
                    pc_d   = tgt;
                    epc_ld = new_exc;
                end else if (fetch_ready) begin
                    pc_d = pc_plus4;
                end
            end
            ST_HOLD: begin
                if (stall) begin
                    buf_cap = redir && new_exc;
                end else begin
                    buf_clr = 1'b1;
                    state_d = ST_RUN;
                    if (pend_exc || !redir) begin
                        pc_d   = pend_tgt;
                        epc_ld = pend_exc;
                        epc_d  = pend_exc_pc;
                    end else begin
                        pc_d   = tgt;
                        epc_ld = new_exc;
                    end
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State and PC registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_p0   <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_p0   <= pc_d;
        end
    end

    pc_redirect_buf #(.XLEN(XLEN)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .capture   (buf_cap),
        .clear     (buf_clr),
        .in_target (tgt),
        .in_exc    (new_exc),
        .in_exc_pc (exc_pc),
        .valid     (pend_valid),
        .target    (pend_tgt),
        .exc       (pend_exc),
        .exc_pc    (pend_exc_pc)
    );

`ifdef PC_EPC_EN
    logic epc_unused_valid;
    assign epc_unused_valid = pend_valid;

    // Exception return address, written on the edge the exception target is applied
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc <= '0;
        end else if (epc_ld) begin
            epc <= epc_d;
        end
    end
`else
    logic unused_epc;
    assign unused_epc = ^{epc_ld, epc_d, pend_valid};
    assign epc        = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: boot, branches, jr kernel rules, stalled
// redirects, interrupt masking, segment wrap and reset during HOLD.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  pc_src;
    logic        branch_taken;
    logic [31:0] branch_target, jump_target, reg_target, exc_pc;
    logic        stall, fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc, pc_plus4, epc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pc_src        (pc_src),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .reg_target    (reg_target),
        .exc_pc        (exc_pc),
        .stall         (stall),
        .fetch_ready   (fetch_ready),
        .fetch_valid   (fetch_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .epc           (epc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_epc;

    initial begin
        reset = 1'b1; pc_src = 3'b000; branch_taken = 1'b0;
        branch_target = '0; jump_target = '0; reg_target = '0; exc_pc = '0;
        stall = 1'b0; fetch_ready = 1'b0;
        step(); step();
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rst_epc", epc, 32'h0);

        // 1: boot sequence
        reset = 1'b0; fetch_ready = 1'b1;
        chk("boot_pc", pc, 32'h8000_0000);
        chk("boot_fv", {31'd0, fetch_valid}, 32'd0);
        step();
        chk("run0_pc", pc, 32'h8000_0000);
        chk("run0_fv", {31'd0, fetch_valid}, 32'd1);
        step();
        chk("run1_pc", pc, 32'h8000_0004);
        step();
        chk("run2_pc", pc, 32'h8000_0008);
        chk("run2_p4", pc_plus4, 32'h8000_000C);

        // 2: branches from user pc
        pc_src = 3'b011; reg_target = 32'h0000_0100;
        step();
        chk("jr_user_pc", pc, 32'h0000_0100);
        pc_src = 3'b001; branch_taken = 1'b0; branch_target = 32'h0000_0200;
        step();
        chk("br_nt_pc", pc, 32'h0000_0104);
        branch_taken = 1'b1;
        step();
        chk("br_t_pc", pc, 32'h0000_0200);

        // 3: jr supervisor-bit rules
        pc_src = 3'b011; reg_target = 32'h0000_0040;
        step();
        chk("jr40_pc", pc, 32'h0000_0040);
        reg_target = 32'h8000_1000;
        step();
        chk("jr_noenter", pc, 32'h0000_1000);
        pc_src = 3'b100;
        step();
        chk("illop_pc", pc, 32'h8000_0004);
        pc_src = 3'b011; reg_target = 32'h0000_2003;
        step();
        chk("jr_leave", pc, 32'h0000_2000);

        // 4: stalled redirect overwritten by exception
        stall = 1'b1; pc_src = 3'b010; jump_target = 32'h0000_0300;
        step();
        chk("stall_hold0", pc, 32'h0000_2000);
        pc_src = 3'b101; exc_pc = 32'h0000_0050;
        step();
        chk("stall_hold1", pc, 32'h0000_2000);
        stall = 1'b0; pc_src = 3'b000;
        step();
        chk("hold_exit_pc", pc, 32'h8000_0008);
`ifdef PC_EPC_EN
        exp_epc = 32'h0000_0050;
`else
        exp_epc = 32'h0000_0000;
`endif
        chk("hold_exit_epc", epc, exp_epc);

        // non-exception buffered target loses to a redirect arriving as stall drops
        stall = 1'b1; pc_src = 3'b010; jump_target = 32'h0000_0400;
        step();
        chk("stall2_hold", pc, 32'h8000_0008);
        stall = 1'b0; jump_target = 32'h0000_0500;
        step();
        chk("drop_newwins", pc, 32'h8000_0500);
        pc_src = 3'b000; fetch_ready = 1'b0;
        step();
        chk("fr0_hold", pc, 32'h8000_0500);
        fetch_ready = 1'b1;

        // 5: interrupt masking and exception entry
        pc_src = 3'b010; jump_target = 32'h0000_0010;
        step();
        chk("kern10_pc", pc, 32'h8000_0010);
        pc_src = 3'b101; exc_pc = 32'h0000_0099;
        step();
        chk("irq_masked", pc, 32'h8000_0014);
        pc_src = 3'b011; reg_target = 32'h0000_0010;
        step();
        chk("user10_pc", pc, 32'h0000_0010);
        pc_src = 3'b101; exc_pc = 32'h0000_000C;
        step();
        chk("irq_pc", pc, 32'h8000_0008);
`ifdef PC_EPC_EN
        exp_epc = 32'h0000_000C;
`else
        exp_epc = 32'h0000_0000;
`endif
        chk("irq_epc", epc, exp_epc);

        // 6: segment wrap
        pc_src = 3'b011; reg_target = 32'h7FFF_FFFC;
        step();
        chk("user_top_pc", pc, 32'h7FFF_FFFC);
        chk("user_wrap_p4", pc_plus4, 32'h0000_0000);
        pc_src = 3'b000;
        step();
        chk("user_wrap_pc", pc, 32'h0000_0000);
        pc_src = 3'b100;
        step();
        pc_src = 3'b010; jump_target = 32'h7FFF_FFFC;
        step();
        chk("kern_top_pc", pc, 32'hFFFF_FFFC);
        chk("kern_wrap_p4", pc_plus4, 32'h8000_0000);
        pc_src = 3'b000;
        step();
        chk("kern_wrap_pc", pc, 32'h8000_0000);

        // reset while holding a buffered redirect
        stall = 1'b1; pc_src = 3'b010; jump_target = 32'h0000_0700;
        step();
        reset = 1'b1;
        #1;
        chk("async_rst_pc", pc, 32'h8000_0000);
        chk("async_rst_fv", {31'd0, fetch_valid}, 32'd0);
        step();
        reset = 1'b0; stall = 1'b0; pc_src = 3'b000;
        step();
        chk("post_rst_boot", pc, 32'h8000_0000);
        step();
        chk("post_rst_seq", pc, 32'h8000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
